frac_interpolator: RTL
======================

Name: frac_interpolator

Overview:
- Rate-3/2 polyphase fractional interpolator: 3 output samples per 2 accepted input samples.
- Mirror of the chain's rate-2/3 fractional decimator; sits on the upconversion side of the DFE filter array.
- Upsample by 3, filter with a 72-tap FIR, keep every 2nd sample; implemented as a 24-tap-per-phase polyphase MAC.
- Input is flow-controlled by in_ready; output is a valid-qualified stream.

Parameters:
DATA_WIDTH, 16, sample width, signed S1.15
DATA_FRAC, 15, sample fraction bits
COEFF_WIDTH, 20, coefficient width, signed S2.18
COEFF_FRAC, 18, coefficient fraction bits
N_TAP, 72, prototype FIR length; must be a multiple of 3 (24 taps per phase)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  filter_in valid; a sample is accepted when valid_in && in_ready at a posedge
in_ready  out  1  block can accept a sample this cycle
filter_in  in  DATA_WIDTH  input sample, S1.15
bypass  in  1  1 = pass filter_in straight through
coeff_wr_en  in  1  load the whole coeff_data_in array at this posedge
coeff_data_in  in  N_TAP x COEFF_WIDTH  coefficient array h[0..N_TAP-1]
coeff_data_out  out  N_TAP x COEFF_WIDTH  stored coefficients (readback)
filter_out  out  DATA_WIDTH  output sample, S1.15
valid_out  out  1  filter_out valid for one cycle
overflow  out  1  pulse with valid_out: output clamped to +32767
underflow  out  1  pulse with valid_out: output clamped to -32768

Behaviour:
- Reset (asynchronous):
  - delay line d[0..23] = 0; FSM = S_A_WAIT.
  - filter_out, valid_out, overflow, underflow = 0.
  - Product/sum pipeline valid flags cleared.
  - Coefficients = impulse: h[0] = 262144 (1.0), all others 0.
- Reset mid-operation: in-flight outputs are discarded; no valid_out is produced for them.
- Polyphase math:
  - phase p output y = sum over i=0..23 of h[3i+p]*d[i], with d[0] the newest sample.
  - Product 36b Q33; 41b accumulator, no internal wrap.
- Output conversion: add 2^17, arithmetic shift right 18 (round half up), saturate to 16b, raise overflow/underflow.
- FSM (bypass=0):
  - S_A_WAIT: in_ready=1. On accept: shift delay line, issue phase 0, go to S_A_P2.
  - S_A_P2: in_ready=0. Issue phase 2 on the same delay line, go to S_B_WAIT.
  - S_B_WAIT: in_ready=1. On accept: shift delay line, issue phase 1, go to S_A_WAIT.
  - With valid_in=0, the FSM holds its wait state indefinitely.
  - Maximum throughput: 2 inputs per 3 cycles; in_ready pattern 1,0,1.
- Pipeline:
  - At the issuing edge, the product registers latch 24 products using the post-shift delay line; the new sample feeds products directly.
  - Next edge: the sum is rounded and saturated into filter_out, with valid_out=1.
  - Latency: accept at edge t gives phase 0 at edge t+1 and phase 2 at edge t+2. B accepted at edge u gives phase 1 at edge u+1.
  - When no output is issued, valid_out=0 and filter_out holds its last value.
- Coefficients:
  - coeff_wr_en=1 loads all N_TAP registers at that edge.
  - Products latched from edge t+1 onward use the new set; outputs already in the product register keep the old set.
  - coeff_data_out always mirrors the registers.
- Bypass=1:
  - filter_out <= filter_in and valid_out <= valid_in, one-edge latency.
  - in_ready=1; overflow/underflow=0; FSM forced to S_A_WAIT; MAC pipeline valid flags cleared; delay line retained.
- Bypass 1->0: resume at S_A_WAIT; the next accepted sample is an A (phase 0/2) sample.
- Simultaneous coeff_wr_en and sample accept: the new coefficients apply to that accept's products.

Test Plan:
1. Reset and defaults: hold rst_n=0 for 5 cycles -> coeff_data_out[0]=262144, others 0; filter_out=0, valid_out=0; in_ready=1 after release. Assert rst_n mid-stream -> no valid_out for in-flight samples.
2. Default impulse, back-to-back valid_in=1, x=1000,2000,3000,4000 -> outputs 1000,0,0,3000,0,0 (6 outputs); in_ready pattern 1,0,1,1,0,1.
3. Load h[0]=h[1]=h[2]=262144, rest 0; x=1000,2000,3000 -> outputs 1000,1000,2000,3000,3000 (zero-order hold).
4. Saturation with h[0]=h[3]=262144:
   - x=30000,30000,30000 -> third input gives 32767 with overflow=1 on that valid_out.
   - x=-30000 x3 -> -32768 with underflow=1.
5. Rounding with h[0]=131072 (0.5): x=3 -> 2; x=-3 -> -1; x=4 -> 2.
6. Bypass and gaps: valid_in toggled randomly with bypass=0 -> output count = 3/2 x accepted, matches the golden model within +-1 LSB. Then bypass=1, x=1234 -> filter_out=1234 one edge later with in_ready=1.

Source files
------------

// File: rtl/frac_interpolator.sv
// rtl/frac_interpolator.sv - rate-3/2 polyphase fractional interpolator (3 outputs per 2 inputs)
//
// Upsample-by-3 / 72-tap FIR / keep-every-2nd, folded into a 24-tap-per-phase
// polyphase MAC. Input samples alternate between "A" (produces phases 0 and 2)
// and "B" (produces phase 1), which gives an in_ready pattern of 1,0,1 at full rate.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in          filter_in valid; accepted when valid_in && in_ready at posedge
//   in_ready          block can accept a sample this cycle
//   filter_in         input sample, S1.15
//   bypass            1 = pass filter_in straight to filter_out (one-edge latency)
//   coeff_wr_en       load the whole coeff_data_in array at this posedge
//   coeff_data_in     packed h[0..N_TAP-1], h[k] at bits [k*COEFF_WIDTH +: COEFF_WIDTH], S2.18
//   coeff_data_out    stored coefficients, same packing
//   filter_out        output sample, S1.15
//   valid_out         filter_out valid for one cycle
//   overflow          pulses with valid_out when the output clamped to the positive limit
//   underflow         pulses with valid_out when the output clamped to the negative limit

module frac_interpolator #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_FRAC   = 15,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18,
    parameter int N_TAP       = 72
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          filter_in,
    input  logic                           bypass,
    input  logic                           coeff_wr_en,
    input  logic [N_TAP*COEFF_WIDTH-1:0]   coeff_data_in,
    output logic [N_TAP*COEFF_WIDTH-1:0]   coeff_data_out,
    output logic [DATA_WIDTH-1:0]          filter_out,
    output logic                           valid_out,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int N_PH      = N_TAP / 3;
    localparam int PW        = DATA_WIDTH + COEFF_WIDTH;
    localparam int AW        = PW + $clog2(N_PH);
    localparam int PROD_FRAC = DATA_FRAC + COEFF_FRAC;
    localparam int OUT_SHIFT = PROD_FRAC - DATA_FRAC;

    localparam logic signed [AW-1:0] RND  = AW'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (DATA_WIDTH - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);
    localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE = COEFF_WIDTH'(1) <<< COEFF_FRAC;

    typedef enum logic [1:0] {
        S_A_WAIT = 2'd0,
        S_A_P2   = 2'd1,
        S_B_WAIT = 2'd2
    } state_t;

    state_t state, next_state;

    logic       shift;
    logic       issue;
    logic [1:0] phase;

    logic signed [DATA_WIDTH-1:0]  dly       [N_PH];
    logic signed [COEFF_WIDTH-1:0] coef      [N_TAP];
    logic signed [COEFF_WIDTH-1:0] coef_eff  [N_TAP];
    logic signed [DATA_WIDTH-1:0]  tap       [N_PH];
    logic signed [COEFF_WIDTH-1:0] coef_sel  [N_PH];
    logic signed [PW-1:0]          prod_next [N_PH];
    logic signed [PW-1:0]          prod      [N_PH];
    logic                          prod_valid;

    logic signed [AW-1:0]          acc;
    logic signed [AW-1:0]          acc_rnd;
    logic signed [AW-1:0]          acc_shift;
    logic                          sat_hi;
    logic                          sat_lo;
    logic [DATA_WIDTH-1:0]         sat_val;

    // ------------------------------------------------------------------
    // Phase sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_A_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        shift      = 1'b0;
        issue      = 1'b0;
        phase      = 2'd0;
        if (bypass) begin
            // Bypass parks the sequencer so the next filtered sample is an A.
            next_state = S_A_WAIT;
            in_ready   = 1'b1;
        end else begin
            case (state)
                S_A_WAIT: begin
                    in_ready = 1'b1;
                    if (valid_in) begin
                        shift      = 1'b1;
                        issue      = 1'b1;
                        phase      = 2'd0;
                        next_state = S_A_P2;
                    end
                end
                S_A_P2: begin
                    issue      = 1'b1;
                    phase      = 2'd2;
                    next_state = S_B_WAIT;
                end
                S_B_WAIT: begin
                    in_ready = 1'b1;
                    if (valid_in) begin
                        shift      = 1'b1;
                        issue      = 1'b1;
                        phase      = 2'd1;
                        next_state = S_A_WAIT;
                    end
                end
                default: begin
                    next_state = S_A_WAIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Coefficient store. A write on the same edge as an issue must already
    // be visible to that issue's products, hence the write-through mux.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAP; k++) begin
                coef[k] <= '0;
            end
            coef[0] <= COEF_ONE;
        end else if (coeff_wr_en) begin
            for (int k = 0; k < N_TAP; k++) begin
                coef[k] <= $signed(coeff_data_in[k*COEFF_WIDTH +: COEFF_WIDTH]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_TAP; k++) begin
            coef_eff[k] = coeff_wr_en ? $signed(coeff_data_in[k*COEFF_WIDTH +: COEFF_WIDTH])
                                      : coef[k];
        end
    end

    always_comb begin
        coeff_data_out = '0;
        for (int k = 0; k < N_TAP; k++) begin
            coeff_data_out[k*COEFF_WIDTH +: COEFF_WIDTH] = coef[k];
        end
    end

    // ------------------------------------------------------------------
    // Delay line, d[0] newest
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PH; i++) begin
                dly[i] <= '0;
            end
        end else if (shift) begin
            dly[0] <= $signed(filter_in);
            for (int i = 1; i < N_PH; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Products see the post-shift line: on an accepting edge the new sample
    // feeds tap 0 directly instead of waiting for the delay register.
    always_comb begin
        for (int i = 0; i < N_PH; i++) begin
            tap[i] = dly[i];
        end
        if (shift) begin
            tap[0] = $signed(filter_in);
            for (int i = 1; i < N_PH; i++) begin
                tap[i] = dly[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PH; i++) begin
            case (phase)
                2'd0:    coef_sel[i] = coef_eff[3*i];
                2'd1:    coef_sel[i] = coef_eff[3*i+1];
                default: coef_sel[i] = coef_eff[3*i+2];
            endcase
            prod_next[i] = $signed({{COEFF_WIDTH{tap[i][DATA_WIDTH-1]}}, tap[i]})
                         * $signed({{DATA_WIDTH{coef_sel[i][COEFF_WIDTH-1]}}, coef_sel[i]});
        end
    end

    // ------------------------------------------------------------------
    // Product register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_valid <= 1'b0;
            for (int i = 0; i < N_PH; i++) begin
                prod[i] <= '0;
            end
        end else begin
            prod_valid <= issue;
            if (issue) begin
                for (int i = 0; i < N_PH; i++) begin
                    prod[i] <= prod_next[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum, round half up, saturate
    // ------------------------------------------------------------------
    always_comb begin
        acc = '0;
        for (int i = 0; i < N_PH; i++) begin
            acc = acc + $signed({{(AW-PW){prod[i][PW-1]}}, prod[i]});
        end
        acc_rnd   = acc + RND;
        acc_shift = acc_rnd >>> OUT_SHIFT;
        sat_hi    = (acc_shift > SMAX);
        sat_lo    = (acc_shift < SMIN);
        if (sat_hi) begin
            sat_val = SMAX[DATA_WIDTH-1:0];
        end else if (sat_lo) begin
            sat_val = SMIN[DATA_WIDTH-1:0];
        end else begin
            sat_val = acc_shift[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_out <= '0;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (bypass) begin
            filter_out <= filter_in;
            valid_out  <= valid_in;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (prod_valid) begin
            filter_out <= sat_val;
            valid_out  <= 1'b1;
            overflow   <= sat_hi;
            underflow  <= sat_lo;
        end else begin
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end
    end

endmodule
